id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Pipelined instruction-decode stage for the 5-stage RV32I core: decodes the IF/ID instruction, reads the register file, generates immediates and ALU controls, and registers everything into the ID/EX pipeline register. Unlike the single-cycle decoder, it detects load-use hazards and stalls IF, and accepts a flush from EX. Sits between the IF/ID register and the EX stage; the WB stage writes back through it.

## Interface
- XLEN, 32: datapath width of register data, PC and immediates (32 or 64).
- RF_RST_VAL, 0: reset value of x1..x31.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous and active-high.
- if_valid  in  1  IF/ID holds a real instruction.
- if_inst  in  32  instruction from IF/ID.
- if_pc  in  XLEN  PC of if_inst.
- wb_we / wb_rd / wb_data  in  1 / 5 / XLEN  register write port from WB.
- ex_flush  in  1  branch/jump taken in EX; kill the instruction in ID.
- id_stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid, ex_pc, ex_rd, ex_rs1, ex_rs2  out  1, XLEN, 5, 5, 5  ID/EX payload.
- ex_regwrite, ex_alusrc, ex_memwrite, ex_memread, ex_memtoreg, ex_is_jal  out  1 each  controls.
- ex_branch  out  2  00 none, 01 beq, 10 bne.
- ex_alu_ctl  out  3  ALU op (package encoding).
- ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN  immediate and operands.

## Operation
- Decode: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111. Any other opcode: all controls 0, ex_valid follows normal rules.
- ALU_ctl from {inst[30], funct3} for R-type; I-ALU ignores inst[30] except for funct3=101 (SRLI only in this core); load/store/jal -> ADD; branch -> SUB.
- ex_branch: 01 if funct3[0]=0, 10 if funct3[0]=1.
- Immediates sign-extended to XLEN: I, S, B (bit 0 = 0), J (bit 0 = 0).
- Register file: 32 x XLEN, x0 reads 0, writes to x0 dropped.
- rs1 used by all decoded types except jal; rs2 used by R, store, branch.
- Load-use hazard: ex_valid & ex_memread & ex_rd!=0 & if_valid & ((rs1 used & ex_rd==rs1) | (rs2 used & ex_rd==rs2)) -> id_stall=1, ID/EX loads a bubble.
- Bubble: ex_valid=0 and every control 0; data fields don't-care (hold 0).
- Priority per edge: rst > ex_flush (bubble, id_stall forced 0) > hazard (bubble) > !if_valid (bubble) > load decoded instruction.

## Timing
- Decode-to-ID/EX latency 1 cycle; id_stall combinational from ID/EX register and if_inst, no register.
- Reset: all ex_* outputs 0, id_stall 0, x1..x31 = RF_RST_VAL.
- Same-cycle WB write and ID read of same register: see Configuration.
- Stall lasts exactly 1 cycle per load-use pair (bubble removes the load from EX).
- rst asserted mid-stall: next cycle outputs all 0, stall drops.

## Configuration
- ID_WB_BYPASS_EN defined: read data = wb_data when wb_we & wb_rd!=0 & wb_rd==rs (write-through bypass).
- Not defined: read returns pre-write value; software/hazard logic elsewhere must cover the WB->ID distance.

## Structure
- Package id_pkg: opcode constants, ALU_CTL_{AND=000, OR=001, ADD=010, XOR=011, SLL=100, SRL=101, SUB=110, SLT=111}, BR_{NONE, EQ, NE}.
- Sub-module id_regfile (32 x XLEN, 2R1W, bypass under the macro); decode and hazard logic stay in the top.

## Test plan
- After rst: add x3,x1,x2 (0x002081B3) -> next cycle ex_valid=1, ex_regwrite=1, ex_alu_ctl=010, ex_rd=3, ex_rs1_data=ex_rs2_data=0.
- WB writes x5=0x1234 with wb_we; next addi x6,x5,-1 (0xFFF28313) -> ex_rs1_data=0x1234, ex_imm=0xFFFFFFFF, ex_alusrc=1.
- lw x7,0(x1) then add x8,x7,x7 -> id_stall=1 for exactly one cycle, one bubble (ex_valid=0), then add issues.
- ex_flush=1 while a hazard is present -> id_stall=0, bubble loaded.
- Same-cycle wb_we for x9=0xABCD with read of x9: bypass enabled -> 0xABCD; disabled -> old value. Write to x0 -> x0 still reads 0.
- beq with funct3=001 (bne) -> ex_branch=10, ex_alu_ctl=110, ex_imm B-type sign-extended with bit 0 = 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants for the pipelined ID stage: opcodes, ALU control and branch codes.
package id_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_CTL_AND = 3'b000,
    ALU_CTL_OR  = 3'b001,
    ALU_CTL_ADD = 3'b010,
    ALU_CTL_XOR = 3'b011,
    ALU_CTL_SLL = 3'b100,
    ALU_CTL_SRL = 3'b101,
    ALU_CTL_SUB = 3'b110,
    ALU_CTL_SLT = 3'b111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } br_e;

  // The ALU has no SLTU/SRA; those encodings fall back to SLT/SRL.
  function automatic alu_ctl_e alu_ctl_decode(input logic bit30, input logic [2:0] funct3);
    alu_ctl_e op;
    unique case (funct3)
      3'b000:  op = bit30 ? ALU_CTL_SUB : ALU_CTL_ADD;
      3'b001:  op = ALU_CTL_SLL;
      3'b010:  op = ALU_CTL_SLT;
      3'b011:  op = ALU_CTL_SLT;
      3'b100:  op = ALU_CTL_XOR;
      3'b101:  op = ALU_CTL_SRL;
      3'b110:  op = ALU_CTL_OR;
      3'b111:  op = ALU_CTL_AND;
      default: op = ALU_CTL_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/ID input, WB write port, EX flush and ID/EX payload of the decode stage.
interface id_stage_pipe_if #(
  parameter int unsigned XLEN = 32
);

  logic            if_valid;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_flush;
  logic            id_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic            ex_regwrite;
  logic            ex_alusrc;
  logic            ex_memwrite;
  logic            ex_memread;
  logic            ex_memtoreg;
  logic            ex_is_jal;
  logic [1:0]      ex_branch;
  logic [2:0]      ex_alu_ctl;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;

  modport master (
    input  if_valid, if_inst, if_pc, wb_we, wb_rd, wb_data, ex_flush,
    output id_stall, ex_valid, ex_pc, ex_rd, ex_rs1, ex_rs2, ex_regwrite, ex_alusrc,
           ex_memwrite, ex_memread, ex_memtoreg, ex_is_jal, ex_branch, ex_alu_ctl, ex_imm,
           ex_rs1_data, ex_rs2_data
  );

  modport slave (
    output if_valid, if_inst, if_pc, wb_we, wb_rd, wb_data, ex_flush,
    input  id_stall, ex_valid, ex_pc, ex_rd, ex_rs1, ex_rs2, ex_regwrite, ex_alusrc,
           ex_memwrite, ex_memread, ex_memtoreg, ex_is_jal, ex_branch, ex_alu_ctl, ex_imm,
           ex_rs1_data, ex_rs2_data
  );

endinterface

// File: rtl/id_regfile.sv
// 32 x XLEN register file, two async reads, one write; x0 hardwired to zero.
// With ID_WB_BYPASS_EN defined, a same-cycle write is forwarded to the read ports.
module id_regfile #(
  parameter int unsigned          XLEN       = 32,
  parameter logic [XLEN-1:0]      RF_RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] rf_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q[0] <= '0;
      for (int i = 1; i < 32; i++) rf_q[i] <= RF_RST_VAL;
    end else if (we_i && (waddr_i != 5'd0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] ra);
    logic [XLEN-1:0] val;
    val = (ra == 5'd0) ? '0 : rf_q[ra];
`ifdef ID_WB_BYPASS_EN
    if (we_i && (waddr_i != 5'd0) && (waddr_i == ra)) val = wdata_i;
`endif
    return val;
  endfunction

  always_comb begin
    rdata_a_o = rd_port(raddr_a_i);
    rdata_b_o = rd_port(raddr_b_i);
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined RV32I decode stage: decode, regfile read, load-use stall, EX flush, ID/EX register.
// Optional WB->ID write-through bypass selected by ID_WB_BYPASS_EN (see id_regfile).
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RF_RST_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  id_stage_pipe_if.master  pipe_io
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            regwrite;
    logic            alusrc;
    logic            memwrite;
    logic            memread;
    logic            memtoreg;
    logic            is_jal;
    logic [1:0]      branch;
    logic [2:0]      alu_ctl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
  } id_ex_t;

  id_ex_t ex_q, ex_d, dec;
  logic [31:0]     inst;
  logic [XLEN-1:0] rs1_rdata, rs2_rdata;
  logic            rs1_used, rs2_used, hazard;

  assign inst = pipe_io.if_inst;

  id_regfile #(
    .XLEN       (XLEN),
    .RF_RST_VAL (RF_RST_VAL)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (pipe_io.wb_we),
    .waddr_i   (pipe_io.wb_rd),
    .wdata_i   (pipe_io.wb_data),
    .raddr_a_i (inst[19:15]),
    .rdata_a_o (rs1_rdata),
    .raddr_b_i (inst[24:20]),
    .rdata_b_o (rs2_rdata)
  );

  always_comb begin
    dec          = '0;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    dec.valid    = pipe_io.if_valid;
    dec.pc       = pipe_io.if_pc;
    dec.rd       = inst[11:7];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.rs1_data = rs1_rdata;
    dec.rs2_data = rs2_rdata;
    case (inst[6:0])
      OPC_R: begin
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
        dec.regwrite = 1'b1;
        dec.alu_ctl  = alu_ctl_decode(inst[30], inst[14:12]);
      end
      OPC_I: begin
        rs1_used     = 1'b1;
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.alu_ctl  = alu_ctl_decode((inst[14:12] == 3'b101) & inst[30], inst[14:12]);
        dec.imm      = {{(XLEN-12){inst[31]}}, inst[31:20]};
      end
      OPC_LOAD: begin
        rs1_used     = 1'b1;
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alu_ctl  = ALU_CTL_ADD;
        dec.imm      = {{(XLEN-12){inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        dec.alu_ctl  = ALU_CTL_ADD;
        dec.imm      = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        dec.branch  = inst[12] ? BR_NE : BR_EQ;
        dec.alu_ctl = ALU_CTL_SUB;
        dec.imm     = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        dec.regwrite = 1'b1;
        dec.is_jal   = 1'b1;
        dec.alu_ctl  = ALU_CTL_ADD;
        dec.imm      = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21],
                        1'b0};
      end
      default: ;
    endcase
  end

  // Load in EX whose destination feeds an operand of the instruction now in ID.
  assign hazard = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) && pipe_io.if_valid &&
                  ((rs1_used && (ex_q.rd == dec.rs1)) || (rs2_used && (ex_q.rd == dec.rs2)));

  assign pipe_io.id_stall = hazard && !pipe_io.ex_flush;

  always_comb begin
    ex_d = dec;
    if (pipe_io.ex_flush || hazard || !pipe_io.if_valid) ex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign pipe_io.ex_valid    = ex_q.valid;
  assign pipe_io.ex_pc       = ex_q.pc;
  assign pipe_io.ex_rd       = ex_q.rd;
  assign pipe_io.ex_rs1      = ex_q.rs1;
  assign pipe_io.ex_rs2      = ex_q.rs2;
  assign pipe_io.ex_regwrite = ex_q.regwrite;
  assign pipe_io.ex_alusrc   = ex_q.alusrc;
  assign pipe_io.ex_memwrite = ex_q.memwrite;
  assign pipe_io.ex_memread  = ex_q.memread;
  assign pipe_io.ex_memtoreg = ex_q.memtoreg;
  assign pipe_io.ex_is_jal   = ex_q.is_jal;
  assign pipe_io.ex_branch   = ex_q.branch;
  assign pipe_io.ex_alu_ctl  = ex_q.alu_ctl;
  assign pipe_io.ex_imm      = ex_q.imm;
  assign pipe_io.ex_rs1_data = ex_q.rs1_data;
  assign pipe_io.ex_rs2_data = ex_q.rs2_data;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed-vector bench for id_stage_pipe with hand-computed expectations.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] ExpX9Same = 32'h0000ABCD;
`else
  localparam logic [31:0] ExpX9Same = 32'h00001111;
`endif

  localparam logic [31:0] InstAddX3  = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] InstAddiX6 = 32'hFFF28313;  // addi x6,x5,-1
  localparam logic [31:0] InstLwX7   = 32'h0000A383;  // lw   x7,0(x1)
  localparam logic [31:0] InstAddX8  = 32'h00738433;  // add  x8,x7,x7
  localparam logic [31:0] InstAddX10 = 32'h00048533;  // add  x10,x9,x0
  localparam logic [31:0] InstAddX11 = 32'h000005B3;  // add  x11,x0,x0
  localparam logic [31:0] InstBne    = 32'hFE209CE3;  // bne  x1,x2,-8
  localparam logic [31:0] InstSw     = 32'h0020A223;  // sw   x2,4(x1)
  localparam logic [31:0] InstJal    = 32'h0100006F;  // jal  x0,+16
  localparam logic [31:0] InstBadOpc = 32'h0000007F;

  id_stage_pipe_if #(.XLEN(32)) pipe_if ();

  id_stage_pipe #(
    .XLEN       (32),
    .RF_RST_VAL (32'h0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pipe_io (pipe_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    pipe_if.if_valid = 1'b1;
    pipe_if.if_inst  = inst;
    pipe_if.if_pc    = pc;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    pipe_if.wb_we   = we;
    pipe_if.wb_rd   = rd;
    pipe_if.wb_data = data;
  endtask

  initial begin
    rst = 1'b1;
    pipe_if.if_valid = 1'b0;
    pipe_if.if_inst  = '0;
    pipe_if.if_pc    = '0;
    pipe_if.ex_flush = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    tick();
    tick();
    check_eq("rst_valid", pipe_if.ex_valid, 1'b0);
    check_eq("rst_regwrite", pipe_if.ex_regwrite, 1'b0);
    check_eq("rst_stall", pipe_if.id_stall, 1'b0);
    rst = 1'b0;

    // R-type after reset
    issue(InstAddX3, 32'h100);
    tick();
    check_eq("add_valid", pipe_if.ex_valid, 1'b1);
    check_eq("add_regwrite", pipe_if.ex_regwrite, 1'b1);
    check_eq("add_alu", pipe_if.ex_alu_ctl, 3'b010);
    check_eq("add_rd", pipe_if.ex_rd, 5'd3);
    check_eq("add_pc", pipe_if.ex_pc, 32'h100);
    check_eq("add_rs1d", pipe_if.ex_rs1_data, 32'h0);
    check_eq("add_rs2d", pipe_if.ex_rs2_data, 32'h0);
    check_eq("add_alusrc", pipe_if.ex_alusrc, 1'b0);

    // WB write x5, bubble while IF empty, then addi reads it
    pipe_if.if_valid = 1'b0;
    wb(1'b1, 5'd5, 32'h1234);
    tick();
    check_eq("empty_bubble", pipe_if.ex_valid, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    issue(InstAddiX6, 32'h104);
    tick();
    check_eq("addi_rs1d", pipe_if.ex_rs1_data, 32'h1234);
    check_eq("addi_imm", pipe_if.ex_imm, 32'hFFFFFFFF);
    check_eq("addi_alusrc", pipe_if.ex_alusrc, 1'b1);
    check_eq("addi_alu", pipe_if.ex_alu_ctl, 3'b010);
    check_eq("addi_rd", pipe_if.ex_rd, 5'd6);

    // Load-use: exactly one stall cycle and one bubble
    issue(InstLwX7, 32'h108);
    tick();
    check_eq("lw_memread", pipe_if.ex_memread, 1'b1);
    check_eq("lw_memtoreg", pipe_if.ex_memtoreg, 1'b1);
    issue(InstAddX8, 32'h10C);
    #1;
    check_eq("lu_stall", pipe_if.id_stall, 1'b1);
    tick();
    check_eq("lu_bubble_valid", pipe_if.ex_valid, 1'b0);
    check_eq("lu_bubble_regwr", pipe_if.ex_regwrite, 1'b0);
    check_eq("lu_stall_drop", pipe_if.id_stall, 1'b0);
    tick();
    check_eq("lu_issue_valid", pipe_if.ex_valid, 1'b1);
    check_eq("lu_issue_rd", pipe_if.ex_rd, 5'd8);
    check_eq("lu_issue_stall", pipe_if.id_stall, 1'b0);

    // Flush overrides a hazard
    issue(InstLwX7, 32'h110);
    tick();
    issue(InstAddX8, 32'h114);
    pipe_if.ex_flush = 1'b1;
    #1;
    check_eq("flush_stall", pipe_if.id_stall, 1'b0);
    tick();
    pipe_if.ex_flush = 1'b0;
    check_eq("flush_valid", pipe_if.ex_valid, 1'b0);
    check_eq("flush_memread", pipe_if.ex_memread, 1'b0);

    // Same-cycle WB write and read of x9
    pipe_if.if_valid = 1'b0;
    wb(1'b1, 5'd9, 32'h1111);
    tick();
    wb(1'b1, 5'd9, 32'hABCD);
    issue(InstAddX10, 32'h118);
    tick();
    check_eq("wb_same_cycle", pipe_if.ex_rs1_data, ExpX9Same);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check_eq("wb_next_cycle", pipe_if.ex_rs1_data, 32'hABCD);

    // Write to x0 is dropped
    wb(1'b1, 5'd0, 32'hDEAD);
    issue(InstAddX11, 32'h11C);
    tick();
    check_eq("x0_same_cycle", pipe_if.ex_rs1_data, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check_eq("x0_after", pipe_if.ex_rs2_data, 32'h0);

    // bne
    issue(InstBne, 32'h120);
    tick();
    check_eq("bne_branch", pipe_if.ex_branch, 2'b10);
    check_eq("bne_alu", pipe_if.ex_alu_ctl, 3'b110);
    check_eq("bne_imm", pipe_if.ex_imm, 32'hFFFFFFF8);
    check_eq("bne_regwrite", pipe_if.ex_regwrite, 1'b0);

    // store, jal, unknown opcode
    issue(InstSw, 32'h124);
    tick();
    check_eq("sw_memwrite", pipe_if.ex_memwrite, 1'b1);
    check_eq("sw_imm", pipe_if.ex_imm, 32'h4);
    check_eq("sw_regwrite", pipe_if.ex_regwrite, 1'b0);
    issue(InstJal, 32'h128);
    tick();
    check_eq("jal_isjal", pipe_if.ex_is_jal, 1'b1);
    check_eq("jal_imm", pipe_if.ex_imm, 32'h10);
    check_eq("jal_regwrite", pipe_if.ex_regwrite, 1'b1);
    issue(InstBadOpc, 32'h12C);
    tick();
    check_eq("bad_valid", pipe_if.ex_valid, 1'b1);
    check_eq("bad_regwrite", pipe_if.ex_regwrite, 1'b0);
    check_eq("bad_alu", pipe_if.ex_alu_ctl, 3'b000);

    // Reset during a stall
    issue(InstLwX7, 32'h130);
    tick();
    issue(InstAddX8, 32'h134);
    #1;
    check_eq("rst_mid_pre", pipe_if.id_stall, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("rst_mid_stall", pipe_if.id_stall, 1'b0);
    check_eq("rst_mid_valid", pipe_if.ex_valid, 1'b0);
    check_eq("rst_mid_rd", pipe_if.ex_rd, 5'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
